// File: rtl/regfile_port_arbiter.sv
// Round-robin sharing of one register-file read port and one write port between clients A and B.
// Zero-sweeps the RAM after reset; define REGFILE_WR_BYPASS_EN to forward same-cycle write data to a matching read.
module regfile_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic              rd_gnt_a,
    output logic              rd_valid_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic              rd_req_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              rd_gnt_b,
    output logic              rd_valid_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_req_a,
    input  logic [ADDR_W-1:0] wr_addr_a,
    input  logic [DATA_W-1:0] wr_data_a,
    output logic              wr_gnt_a,
    input  logic              wr_req_b,
    input  logic [ADDR_W-1:0] wr_addr_b,
    input  logic [DATA_W-1:0] wr_data_b,
    output logic              wr_gnt_b,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic              ram_stall,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_wen,
    output logic              init_done
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state, state_next;
    logic [ADDR_W-1:0] init_cnt;
    logic              rd_pri;
    logic              wr_pri;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_valid_a_q, rd_valid_b_q;
    logic [DATA_W-1:0] ret_data;

    // Priority pointers: 0 favours A, 1 favours B when both clients request.
    always_comb begin
        state_next  = state;
        rd_gnt_a    = 1'b0;
        rd_gnt_b    = 1'b0;
        wr_gnt_a    = 1'b0;
        wr_gnt_b    = 1'b0;
        ram_rd_addr = rd_addr_q;
        ram_stall   = 1'b1;
        ram_wen     = 1'b0;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        if (rst) begin
            state_next = INIT;
            ram_wen    = 1'b1;
        end else begin
            case (state)
                INIT: begin
                    ram_wen     = 1'b1;
                    ram_wr_addr = init_cnt;
                    if (init_cnt == LAST_ADDR)
                        state_next = RUN;
                end
                RUN: begin
                    rd_gnt_a  = rd_req_a & (~rd_req_b | ~rd_pri);
                    rd_gnt_b  = rd_req_b & (~rd_req_a | rd_pri);
                    wr_gnt_a  = wr_req_a & (~wr_req_b | ~wr_pri);
                    wr_gnt_b  = wr_req_b & (~wr_req_a | wr_pri);
                    ram_stall = ~(rd_gnt_a | rd_gnt_b);
                    if (rd_gnt_a)
                        ram_rd_addr = rd_addr_a;
                    else if (rd_gnt_b)
                        ram_rd_addr = rd_addr_b;
                    ram_wen = wr_gnt_a | wr_gnt_b;
                    if (wr_gnt_a) begin
                        ram_wr_addr = wr_addr_a;
                        ram_wr_data = wr_data_a;
                    end else if (wr_gnt_b) begin
                        ram_wr_addr = wr_addr_b;
                        ram_wr_data = wr_data_b;
                    end
                end
                default: state_next = INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= INIT;
            init_cnt     <= '0;
            rd_pri       <= 1'b0;
            wr_pri       <= 1'b0;
            rd_addr_q    <= '0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
            init_done    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == INIT)
                init_cnt <= init_cnt + 1'b1;
            if (rd_gnt_a)
                rd_pri <= 1'b1;
            else if (rd_gnt_b)
                rd_pri <= 1'b0;
            if (wr_gnt_a)
                wr_pri <= 1'b1;
            else if (wr_gnt_b)
                wr_pri <= 1'b0;
            if (rd_gnt_a | rd_gnt_b)
                rd_addr_q <= ram_rd_addr;
            rd_valid_a_q <= rd_gnt_a;
            rd_valid_b_q <= rd_gnt_b;
            init_done    <= (state_next == RUN);
        end
    end

`ifdef REGFILE_WR_BYPASS_EN
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;

    // A read granted alongside a write to the same address returns the new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            byp_hit  <= 1'b0;
            byp_data <= '0;
        end else begin
            byp_hit  <= ~ram_stall & (wr_gnt_a | wr_gnt_b) & (ram_rd_addr == ram_wr_addr);
            byp_data <= ram_wr_data;
        end
    end

    assign ret_data = byp_hit ? byp_data : ram_rd_data;
`else
    assign ret_data = ram_rd_data;
`endif

    // A reset landing on the return cycle drops the pending read.
    assign rd_valid_a = rd_valid_a_q & ~rst;
    assign rd_valid_b = rd_valid_b_q & ~rst;
    assign rd_data_a  = rd_valid_a ? ret_data : '0;
    assign rd_data_b  = rd_valid_b ? ret_data : '0;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter: directed scenarios plus randomized traffic against a
// shadow-memory reference model; honours REGFILE_WR_BYPASS_EN when defined.
module tb_regfile_port_arbiter;

    localparam int DEPTH = 32;
`ifdef REGFILE_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk, rst;
    logic       rd_req_a, rd_req_b, wr_req_a, wr_req_b;
    logic [4:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [3:0] wr_data_a, wr_data_b;
    logic       rd_gnt_a, rd_gnt_b, rd_valid_a, rd_valid_b, wr_gnt_a, wr_gnt_b;
    logic [3:0] rd_data_a, rd_data_b;
    logic [4:0] ram_rd_addr, ram_wr_addr;
    logic [3:0] ram_rd_data, ram_wr_data;
    logic       ram_stall, ram_wen, init_done;

    int checks   = 0;
    int failures = 0;

    regfile_port_arbiter #(.ADDR_W(5), .DATA_W(4)) dut (
        .clk(clk), .rst(rst),
        .rd_req_a(rd_req_a), .rd_addr_a(rd_addr_a), .rd_gnt_a(rd_gnt_a),
        .rd_valid_a(rd_valid_a), .rd_data_a(rd_data_a),
        .rd_req_b(rd_req_b), .rd_addr_b(rd_addr_b), .rd_gnt_b(rd_gnt_b),
        .rd_valid_b(rd_valid_b), .rd_data_b(rd_data_b),
        .wr_req_a(wr_req_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a), .wr_gnt_a(wr_gnt_a),
        .wr_req_b(wr_req_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b), .wr_gnt_b(wr_gnt_b),
        .ram_rd_addr(ram_rd_addr), .ram_stall(ram_stall), .ram_rd_data(ram_rd_data),
        .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_wen(ram_wen),
        .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first synchronous RAM; a stalled cycle keeps the previous read result.
    logic [3:0] ram_mem [DEPTH];
    logic [3:0] ram_q;
    assign ram_rd_data = ram_q;
    always @(posedge clk) begin
        if (!ram_stall)
            ram_q <= ram_mem[ram_rd_addr];
        if (ram_wen)
            ram_mem[ram_wr_addr] <= ram_wr_data;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit ra, input logic [4:0] aa, input bit rb, input logic [4:0] ab,
                                 input bit wa, input logic [4:0] waa, input logic [3:0] wda,
                                 input bit wb, input logic [4:0] wab, input logic [3:0] wdb);
        rd_req_a = ra; rd_addr_a = aa; rd_req_b = rb; rd_addr_b = ab;
        wr_req_a = wa; wr_addr_a = waa; wr_data_a = wda;
        wr_req_b = wb; wr_addr_b = wab; wr_data_b = wdb;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: shadow memory, sweep counter, priority owners and the pending read return.
    bit         m_init = 1'b1, m_done = 1'b0, m_rpri = 1'b0, m_wpri = 1'b0;
    int         m_cnt = 0;
    logic [3:0] shadow [DEPTH];
    bit         m_va = 1'b0, m_vb = 1'b0, m_last_ok = 1'b0;
    logic [3:0] m_dat = '0;
    logic [4:0] m_last = '0;
    bit         g_ra, g_rb, g_wa, g_wb;
    logic [4:0] e_ra, e_wa;
    logic [3:0] e_rv, e_wd;

    always @(negedge clk) begin
        checkOutput("rd_valid_a", int'(rd_valid_a), (!rst && m_va) ? 1 : 0);
        checkOutput("rd_valid_b", int'(rd_valid_b), (!rst && m_vb) ? 1 : 0);
        checkOutput("rd_data_a", int'(rd_data_a), (!rst && m_va) ? int'(m_dat) : 0);
        checkOutput("rd_data_b", int'(rd_data_b), (!rst && m_vb) ? int'(m_dat) : 0);
        checkOutput("init_done", int'(init_done), int'(m_done));
        if (rst || m_init) begin
            g_ra = 1'b0; g_rb = 1'b0; g_wa = 1'b0; g_wb = 1'b0;
            checkOutput("idle_gnts", int'({rd_gnt_a, rd_gnt_b, wr_gnt_a, wr_gnt_b}), 0);
            checkOutput("idle_stall", int'(ram_stall), 1);
            checkOutput("idle_wen", int'(ram_wen), 1);
            m_va = 1'b0; m_vb = 1'b0;
        end
        if (rst) begin
            m_init = 1'b1; m_cnt = 0; m_done = 1'b0;
            m_rpri = 1'b0; m_wpri = 1'b0; m_last_ok = 1'b0;
            for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        end else if (m_init) begin
            checkOutput("sweep_wr_addr", int'(ram_wr_addr), m_cnt);
            checkOutput("sweep_wr_data", int'(ram_wr_data), 0);
            if (m_cnt == DEPTH - 1) begin
                m_init = 1'b0;
                m_done = 1'b1;
            end
            m_cnt++;
        end else begin
            if (rd_req_a && rd_req_b) begin
                g_ra = (m_rpri == 1'b0); g_rb = !g_ra;
            end else begin
                g_ra = rd_req_a; g_rb = rd_req_b;
            end
            if (wr_req_a && wr_req_b) begin
                g_wa = (m_wpri == 1'b0); g_wb = !g_wa;
            end else begin
                g_wa = wr_req_a; g_wb = wr_req_b;
            end
            checkOutput("rd_gnt_a", int'(rd_gnt_a), int'(g_ra));
            checkOutput("rd_gnt_b", int'(rd_gnt_b), int'(g_rb));
            checkOutput("wr_gnt_a", int'(wr_gnt_a), int'(g_wa));
            checkOutput("wr_gnt_b", int'(wr_gnt_b), int'(g_wb));
            checkOutput("ram_stall", int'(ram_stall), (g_ra || g_rb) ? 0 : 1);
            checkOutput("ram_wen", int'(ram_wen), (g_wa || g_wb) ? 1 : 0);
            e_wa = g_wa ? wr_addr_a : wr_addr_b;
            e_wd = g_wa ? wr_data_a : wr_data_b;
            if (g_ra || g_rb) begin
                e_ra = g_ra ? rd_addr_a : rd_addr_b;
                checkOutput("ram_rd_addr", int'(ram_rd_addr), int'(e_ra));
                e_rv = shadow[e_ra];
                if (BYP && (g_wa || g_wb) && e_wa == e_ra)
                    e_rv = e_wd;
                m_dat = e_rv;
                m_last = e_ra;
                m_last_ok = 1'b1;
                m_rpri = g_ra;
            end else if (m_last_ok) begin
                checkOutput("ram_rd_addr_hold", int'(ram_rd_addr), int'(m_last));
            end
            if (g_wa || g_wb) begin
                checkOutput("ram_wr_addr", int'(ram_wr_addr), int'(e_wa));
                checkOutput("ram_wr_data", int'(ram_wr_data), int'(e_wd));
                shadow[e_wa] = e_wd;
                m_wpri = g_wa;
            end
            m_va = g_ra;
            m_vb = g_rb;
        end
    end

    bit         pr_a, pr_b, pw_a, pw_b;
    logic [4:0] sra, srb, swa, swb;
    logic [3:0] sda, sdb;

    initial begin
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = 4'($urandom_range(1, 15));
        ram_q = '0;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;

        // Sweep with every client requesting: no grants, addresses 0..31, data 0.
        applyStimulus(1, 3, 1, 7, 1, 1, 5, 1, 2, 6);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            checkOutput("t1_addr", int'(ram_wr_addr), i);
            checkOutput("t1_gnt", int'({rd_gnt_a, rd_gnt_b, wr_gnt_a, wr_gnt_b}), 0);
            checkOutput("t1_done_low", int'(init_done), 0);
            step();
            if (i == DEPTH - 1)
                applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        checkOutput("t1_done_high", int'(init_done), 1);

        step(); applyStimulus(0, 0, 0, 0, 1, 3, 3, 0, 0, 0);
        @(negedge clk); checkOutput("t2_wr3", int'(wr_gnt_a), 1);
        step(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7, 7);
        @(negedge clk); checkOutput("t2_wr7", int'(wr_gnt_b), 1);

        // Both readers held for four cycles: A, B, A, B with data one cycle later.
        for (int k = 0; k < 5; k++) begin
            step();
            if (k < 4) applyStimulus(1, 3, 1, 7, 0, 0, 0, 0, 0, 0);
            else       applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            checkOutput("t2_gnt_a", int'(rd_gnt_a), (k < 4 && k % 2 == 0) ? 1 : 0);
            checkOutput("t2_gnt_b", int'(rd_gnt_b), (k < 4 && k % 2 == 1) ? 1 : 0);
            checkOutput("t2_data_a", int'(rd_data_a), (k == 1 || k == 3) ? 3 : 0);
            checkOutput("t2_data_b", int'(rd_data_b), (k == 2 || k == 4) ? 7 : 0);
        end

        step(); applyStimulus(0, 0, 0, 0, 1, 9, 5, 1, 9, 6);
        @(negedge clk);
        checkOutput("t3_gnt_a", int'({wr_gnt_a, wr_gnt_b}), 2);
        checkOutput("t3_data5", int'(ram_wr_data), 5);
        step(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9, 6);
        @(negedge clk);
        checkOutput("t3_gnt_b", int'({wr_gnt_a, wr_gnt_b}), 1);
        step(); applyStimulus(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t3_rd9_valid", int'(rd_valid_a), 1);
        checkOutput("t3_rd9_data", int'(rd_data_a), 6);

        step(); applyStimulus(0, 0, 1, 2, 1, 2, 4'hA, 0, 0, 0);
        @(negedge clk);
        checkOutput("t4_same_cycle_gnts", int'({rd_gnt_b, wr_gnt_a}), 3);
        step(); applyStimulus(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t4_raw_data", int'(rd_data_b), BYP ? 10 : 0);
        step(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t4_later_data", int'(rd_data_a), 10);

        // Reset lands on the return cycle of a granted read.
        step(); applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); checkOutput("t5_gnt", int'(rd_gnt_a), 1);
        step(); rst = 1'b1; applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); checkOutput("t5_valid_dropped", int'(rd_valid_a), 0);
        step(); rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_done_low", int'(init_done), 0);
        checkOutput("t5_sweep_addr0", int'(ram_wr_addr), 0);
        checkOutput("t5_sweep_wen", int'(ram_wen), 1);

        // Random traffic; requesters hold request, address and data until granted.
        pr_a = 0; pr_b = 0; pw_a = 0; pw_b = 0;
        sra = '0; srb = '0; swa = '0; swb = '0; sda = '0; sdb = '0;
        for (int it = 0; it < 2500; it++) begin
            step();
            rst = (it == 1500);
            if (pr_a && g_ra) pr_a = 0;
            if (pr_b && g_rb) pr_b = 0;
            if (pw_a && g_wa) pw_a = 0;
            if (pw_b && g_wb) pw_b = 0;
            if (!pr_a && $urandom_range(0, 99) < 55) begin pr_a = 1; sra = 5'($urandom_range(0, 7)); end
            if (!pr_b && $urandom_range(0, 99) < 55) begin pr_b = 1; srb = 5'($urandom_range(0, 7)); end
            if (!pw_a && $urandom_range(0, 99) < 55) begin
                pw_a = 1; swa = 5'($urandom_range(0, 7)); sda = 4'($urandom_range(0, 15));
            end
            if (!pw_b && $urandom_range(0, 99) < 55) begin
                pw_b = 1; swb = 5'($urandom_range(0, 7)); sdb = 4'($urandom_range(0, 15));
            end
            applyStimulus(pr_a, sra, pr_b, srb, pw_a, swa, sda, pw_b, swb, sdb);
        end
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
